// File: rtl/srff_checker.sv
// rtl/srff_checker.sv - SR flip-flop behaviour checker with reference model, error and forbidden-input counters.
// Optional complement-output check is enabled by defining SRFF_CHK_QB_EN.
module srff_checker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sr,
    input  logic       q,
    input  logic       qb,
    input  logic       clr,
    output logic       err_pulse,
    output logic       err_sticky,
    output logic [7:0] err_cnt,
    output logic [7:0] forbid_cnt,
    output logic       known
);

    localparam logic S_UNKNOWN = 1'b0;
    localparam logic S_TRACK   = 1'b1;

    logic       r_state;
    logic       w_next_state;
    logic       r_exp;
    logic       w_compare;
    logic       w_q_bad;
    logic       w_qb_bad;
    logic       w_mismatch;
    logic       w_forbid;
    logic       r_err_pulse;
    logic       r_err_sticky;
    logic [7:0] r_err_cnt;
    logic [7:0] r_forbid_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_UNKNOWN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (sr)
            2'b01, 2'b10: w_next_state = S_TRACK;
            2'b11:        w_next_state = S_UNKNOWN;
            default:      w_next_state = r_state;
        endcase
    end

    // q sampled now reflects the sr seen on the previous edge, held in r_exp.
    always_comb begin
        w_compare = (r_state == S_TRACK);
        w_q_bad   = (q != r_exp);
    end

`ifdef SRFF_CHK_QB_EN
    assign w_qb_bad = (qb != ~q);
`else
    logic w_unused_qb;
    assign w_unused_qb = qb;
    assign w_qb_bad    = 1'b0;
`endif

    assign w_mismatch = w_compare && (w_q_bad || w_qb_bad);
    assign w_forbid   = (sr == 2'b11);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_exp <= 1'b0;
        end else if (sr == 2'b01) begin
            r_exp <= 1'b0;
        end else if (sr == 2'b10) begin
            r_exp <= 1'b1;
        end
    end

    // A clear in the same cycle as an event leaves that event counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_pulse  <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_cnt    <= 8'd0;
            r_forbid_cnt <= 8'd0;
        end else begin
            r_err_pulse <= w_mismatch;
            if (clr) begin
                r_err_sticky <= w_mismatch;
                r_err_cnt    <= {7'd0, w_mismatch};
                r_forbid_cnt <= {7'd0, w_forbid};
            end else begin
                if (w_mismatch) begin
                    r_err_sticky <= 1'b1;
                    if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end
                if (w_forbid && (r_forbid_cnt != 8'hFF)) begin
                    r_forbid_cnt <= r_forbid_cnt + 8'd1;
                end
            end
        end
    end

    assign err_pulse  = r_err_pulse;
    assign err_sticky = r_err_sticky;
    assign err_cnt    = r_err_cnt;
    assign forbid_cnt = r_forbid_cnt;
    assign known      = r_state;

endmodule

// File: tb/tb_srff_checker.sv
// tb/tb_srff_checker.sv - randomized and directed self-checking bench for srff_checker.
module tb_srff_checker;

    logic       clk;
    logic       rst_n;
    logic [1:0] sr;
    logic       q;
    logic       qb;
    logic       clr;
    logic       err_pulse;
    logic       err_sticky;
    logic [7:0] err_cnt;
    logic [7:0] forbid_cnt;
    logic       known;

    srff_checker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sr         (sr),
        .q          (q),
        .qb         (qb),
        .clr        (clr),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt),
        .forbid_cnt (forbid_cnt),
        .known      (known)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: expected q as -1 (undefined), 0 or 1; plain integer counters.
    int m_exp    = -1;
    int m_pulse  = 0;
    int m_sticky = 0;
    int m_err    = 0;
    int m_forbid = 0;
    int pulses_seen = 0;

    // Ideal SR flip-flop used to drive a correct q.
    logic ff_q   = 1'b0;
    bit   follow = 1'b1;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_edge();
        bit mis;
        bit ev_forbid;
        if (!rst_n) begin
            m_exp = -1; m_pulse = 0; m_sticky = 0; m_err = 0; m_forbid = 0;
            return;
        end
        mis = (m_exp >= 0) && (int'(q) != m_exp);
`ifdef SRFF_CHK_QB_EN
        if (m_exp >= 0 && qb == q) mis = 1'b1;
`endif
        ev_forbid = (sr == 2'b11);
        if (clr) begin m_err = 0; m_forbid = 0; m_sticky = 0; end
        if (mis) begin m_err = sat(m_err + 1); m_sticky = 1; end
        if (ev_forbid) m_forbid = sat(m_forbid + 1);
        m_pulse = mis;
        if (sr == 2'b01) m_exp = 0;
        else if (sr == 2'b10) m_exp = 1;
        else if (sr == 2'b11) m_exp = -1;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        if (sr == 2'b01) ff_q = 1'b0;
        else if (sr == 2'b10) ff_q = 1'b1;
        else if (sr == 2'b11) ff_q = 1'($urandom);
        #1;
        if (err_pulse) pulses_seen++;
        if (err_pulse != m_pulse[0] || err_sticky != m_sticky[0] || int'(err_cnt) != m_err
            || int'(forbid_cnt) != m_forbid || known != (m_exp >= 0)) begin
            check("pulse", int'(err_pulse), m_pulse);
            check("sticky", int'(err_sticky), m_sticky);
            check("err_cnt", int'(err_cnt), m_err);
            check("forbid_cnt", int'(forbid_cnt), m_forbid);
            check("known", int'(known), int'(m_exp >= 0));
        end else begin
            check("cycle", 1, 1 - int'(err_pulse != m_pulse[0]));
        end
        if (follow) begin q = ff_q; qb = ~ff_q; end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0; clr = 1'b0; sr = 2'b00;
        repeat (n) step();
        rst_n = 1'b1;
        ff_q = 1'b0; follow = 1'b1; q = 1'b0; qb = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; sr = 2'b00; q = 1'b0; qb = 1'b1; clr = 1'b0;

        do_reset(2);
        check("rst_err_cnt", int'(err_cnt), 0);
        check("rst_known", int'(known), 0);
        check("rst_forbid", int'(forbid_cnt), 0);

        // sr held 00 with q toggling: model never defined
        follow = 1'b0; pulses_seen = 0;
        for (int i = 0; i < 4; i++) begin q = i[0]; qb = ~q; step(); end
        check("idle_known", int'(known), 0);
        check("idle_err", int'(err_cnt), 0);
        check("idle_pulses", pulses_seen, 0);

        // 00,01,10,11 each for two edges with a correct flip-flop
        do_reset(1);
        sr = 2'b00; step(); step();
        check("seq_known_00", int'(known), 0);
        sr = 2'b01; step();
        check("seq_known_01", int'(known), 1);
        step();
        sr = 2'b10; step(); step();
        sr = 2'b11; step();
        check("seq_known_11", int'(known), 0);
        step();
        check("seq_forbid", int'(forbid_cnt), 2);
        check("seq_err", int'(err_cnt), 0);

        // set, then q stuck low for three compares, then clear
        do_reset(1);
        sr = 2'b10; step();
        follow = 1'b0; q = 1'b0; qb = 1'b1; sr = 2'b00; pulses_seen = 0;
        repeat (3) step();
        check("stuck_pulses", pulses_seen, 3);
        check("stuck_err", int'(err_cnt), 3);
        check("stuck_sticky", int'(err_sticky), 1);
        q = 1'b1; qb = 1'b0; clr = 1'b1; step(); clr = 1'b0;
        check("clr_err", int'(err_cnt), 0);
        check("clr_sticky", int'(err_sticky), 0);
        follow = 1'b1;

        // forbidden input held long enough to saturate
        do_reset(1);
        sr = 2'b11;
        repeat (300) step();
        check("sat_forbid", int'(forbid_cnt), 255);
        check("sat_known", int'(known), 0);

        // complement output wrong for one compare
        do_reset(1);
        sr = 2'b10; step();
        follow = 1'b0; sr = 2'b00; q = 1'b1; qb = 1'b1; step();
`ifdef SRFF_CHK_QB_EN
        check("qb_err", int'(err_cnt), 1);
`else
        check("qb_err", int'(err_cnt), 0);
`endif
        follow = 1'b1;

        // reset while a mismatch is pending
        do_reset(1);
        sr = 2'b10; step();
        follow = 1'b0; q = 1'b0; qb = 1'b1; sr = 2'b00; rst_n = 1'b0; step();
        rst_n = 1'b1;
        check("rstp_pulse", int'(err_pulse), 0);
        check("rstp_known", int'(known), 0);
        check("rstp_err", int'(err_cnt), 0);
        check("rstp_sticky", int'(err_sticky), 0);
        step();
        check("rstp_after", int'(err_pulse), 0);
        follow = 1'b1; ff_q = 1'b0; q = 1'b0; qb = 1'b1;

        // randomized traffic with occasional faults, clears and resets
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            sr = (r < 40) ? 2'b00 : (r < 65) ? 2'b01 : (r < 90) ? 2'b10 : 2'b11;
            clr = ($urandom_range(0, 49) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 9) == 0) q = 1'($urandom);
            if ($urandom_range(0, 9) == 0) qb = 1'($urandom);
            step();
            if (!rst_n) ff_q = 1'b0;
        end
        rst_n = 1'b1; clr = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/srff_checker.md
SRFF_CHECKER -- requirements
Module: srff_checker

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-003 SHALL have port sr  input  2  excitation observed at SR flip-flop input; sr[1]=S, sr[0]=R.
REQ-004 SHALL have port q  input  1  observed flip-flop true output.
REQ-005 SHALL have port qb  input  1  observed flip-flop complement output.
REQ-006 SHALL have port clr  input  1  synchronous clear of counters and sticky flag; model state untouched.
REQ-007 SHALL have port err_pulse  output  1  one-cycle flag: mismatch detected this cycle.
REQ-008 SHALL have port err_sticky  output  1  set on any mismatch; held until clr or reset.
REQ-009 SHALL have port err_cnt  output  8  mismatch count, saturating at 255.
REQ-010 SHALL have port forbid_cnt  output  8  count of sr=11 samples, saturating at 255.
REQ-011 SHALL have port known  output  1  high while the reference model holds a defined expected q.

Function
REQ-012 SHALL implement a two-state FSM: UNKNOWN (expected q undefined) and TRACK (expected q defined).
REQ-013 SHALL update the model each edge from sampled sr: 00 hold; 01 expected=0; 10 expected=1; 11 undefined.
REQ-014 SHALL transition UNKNOWN->TRACK on sampled sr=01 or sr=10; sr=00 in UNKNOWN stays UNKNOWN.
REQ-015 SHALL transition TRACK->UNKNOWN on sampled sr=11; sr=00/01/10 stay in TRACK.
REQ-016 SHALL compare q against expected at the edge following the sr sample (one-cycle latency) only when the FSM was in TRACK at that edge.
REQ-017 SHALL register err_pulse high for exactly one cycle per mismatching compare edge; no compare, no pulse.
REQ-018 SHALL increment forbid_cnt on every edge sampling sr=11, in either state.
REQ-019 SHALL hold err_cnt and forbid_cnt at 255 once reached; no wrap-around.
REQ-020 SHALL, on clr with a same-cycle event, clear then count the event (counter=1, sticky=1 on mismatch).
REQ-021 SHALL drive known = (state==TRACK), registered.
REQ-022 SHALL treat a mismatch in the same cycle as sr=11 as counted; the model still goes UNKNOWN.

Reset
REQ-023 SHALL, with rst_n low at a rising edge, force state UNKNOWN, expected q 0, err_pulse 0, err_sticky 0, err_cnt 0, forbid_cnt 0, known 0.
REQ-024 SHALL give reset priority over clr and all events; no compare on the first edge after rst_n deasserts.
REQ-025 SHALL, on reset mid-operation, discard any pending compare with no err_pulse.

Configuration
REQ-026 SHALL compile a complement check when SRFF_CHK_QB_EN is defined: at every TRACK compare edge, qb != ~q counts as a mismatch, independent of the q check. Both failing in one cycle count once.
REQ-027 SHALL ignore qb entirely when SRFF_CHK_QB_EN is undefined.

Verification
REQ-028 SHALL cover: reset, then sr=00 for 4 edges with q toggling -> known=0, err_cnt=0, no err_pulse.
REQ-029 SHALL cover: sr sequence 00,01,10,11, each held 2 edges, with a correct FF -> known rises after the 01 sample and falls after the 11 sample; forbid_cnt=2; err_cnt=0.
REQ-030 SHALL cover: sr=10 then q forced 0 for 3 edges -> 3 err_pulse, err_cnt=3, err_sticky=1; clr pulse -> both 0.
REQ-031 SHALL cover: sr=11 held 300 edges -> forbid_cnt=255 saturated; known=0.
REQ-032 SHALL cover: with SRFF_CHK_QB_EN, TRACK with q=1, qb=1 for 1 edge -> err_cnt=1; without the macro -> err_cnt=0.
REQ-033 SHALL cover: rst_n low for 1 edge while a mismatch is pending -> no err_pulse, all outputs at reset values.
